// File: rtl/mode_gen_if.sv
// Handshake bundle between the mode_gen burst driver and its stimulus/receiver side.
interface mode_gen_if #(
  parameter int unsigned LEN_W = 8
) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic             r_in;
  logic             f_in;
  logic             do_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, len, r_in, f_in,
    input  do_out, busy, done, err
  );

  modport slave (
    input  start, len, r_in, f_in,
    output do_out, busy, done, err
  );
endinterface

// File: rtl/mode_gen.sv
// Burst driver: asserts do_out for len cycles, then waits for the receiver's finish pulse.
// Optional WAIT_F timeout is enabled by defining MODE_GEN_TIMEOUT_EN.
module mode_gen #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned TO_CYC = 8
) (
  input logic       clk,
  input logic       rst_n,
  mode_gen_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StWaitF = 2'd2,
    StFin   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             r_seen_q, r_seen_d;
  logic             proto_q, proto_d;
  logic             do_out_q, busy_q, done_q, err_q;
  logic             done_d, err_d;

`ifdef MODE_GEN_TIMEOUT_EN
  localparam int unsigned ToW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [ToW-1:0] to_q, to_d;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_seen_d = r_seen_q;
    proto_d  = proto_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef MODE_GEN_TIMEOUT_EN
    to_d     = to_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            cnt_d    = bus.len;
            r_seen_d = 1'b0;
            proto_d  = 1'b0;
            state_d  = StDrive;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      StDrive: begin
        r_seen_d = r_seen_q | bus.r_in;
        // A finish pulse before the burst is fully driven is a protocol violation.
        proto_d  = proto_q | bus.f_in;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) begin
          state_d = StWaitF;
`ifdef MODE_GEN_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      StWaitF: begin
        r_seen_d = r_seen_q | bus.r_in;
`ifdef MODE_GEN_TIMEOUT_EN
        to_d     = to_q + 1'b1;
`endif
        if (bus.f_in) begin
          state_d = StFin;
          done_d  = 1'b1;
          err_d   = ~r_seen_d | proto_q;
`ifdef MODE_GEN_TIMEOUT_EN
        end else if (to_q == ToW'(TO_CYC - 1)) begin
          state_d = StFin;
          done_d  = 1'b1;
          err_d   = 1'b1;
`endif
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      r_seen_q <= 1'b0;
      proto_q  <= 1'b0;
      do_out_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MODE_GEN_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_seen_q <= r_seen_d;
      proto_q  <= proto_d;
      do_out_q <= (state_d == StDrive);
      busy_q   <= (state_d == StDrive) || (state_d == StWaitF);
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef MODE_GEN_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign bus.do_out = do_out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: doc/mode_gen.md
MODE_GEN -- requirements
Module: mode_gen

Interface
REQ-001 Parameter LEN_W, default 8, width of the burst-length input and internal length counter.
REQ-002 Parameter TO_CYC, default 8, maximum cycles spent in WAIT_F awaiting f_in before timeout.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one burst; sampled only in IDLE.
REQ-006 len  input  LEN_W  burst length in cycles; captured with start.
REQ-007 r_in  input  1  receiver "running" flag, returned from the far end.
REQ-008 f_in  input  1  receiver "finished" pulse, returned from the far end.
REQ-009 do_out  output  1  registered strobe to the receiver's do input.
REQ-010 busy  output  1  registered; high from the cycle after accepted start until done.
REQ-011 done  output  1  registered one-cycle pulse ending every accepted burst.
REQ-012 err  output  1  registered; valid only while done=1.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, WAIT_F and FIN; encoding values 0..3 in that order; illegal encodings go to IDLE.
REQ-014 In IDLE with start=1 and len!=0: load counter with len, clear r_seen, go to DRIVE; do_out=1 and busy=1 in the next cycle.
REQ-015 In IDLE with start=1 and len=0: stay IDLE, no do_out; done=1 and err=1 for exactly one cycle, busy stays 0.
REQ-016 In DRIVE do_out SHALL remain 1 for exactly len consecutive cycles, counter decrementing each cycle; on the last cycle go to WAIT_F.
REQ-017 In WAIT_F do_out=0; a timeout counter starts at 0 and increments each cycle.
REQ-018 r_seen SHALL set on any cycle in DRIVE or WAIT_F where r_in=1, including the cycle f_in is sampled.
REQ-019 In WAIT_F with f_in=1: go to FIN; in the FIN cycle done=1, err=!r_seen, busy=0; next state IDLE.
REQ-020 f_in=1 while in DRIVE SHALL be recorded as a protocol error, forcing err=1 at the burst's done.
REQ-021 start while busy=1 or in FIN SHALL be ignored, not queued.
REQ-022 r_in and f_in in IDLE SHALL be ignored.
REQ-023 End-to-end timing with a conforming receiver: f_in arrives 2 cycles after do_out falls; burst latency start-to-done = len+4 cycles.
REQ-024 len=2**LEN_W-1 SHALL be supported without counter wrap.
REQ-025 done SHALL be 0 in all cycles other than those defined in REQ-015 and REQ-019.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, do_out=0, busy=0, done=0, err=0, counters and r_seen cleared.
REQ-027 Reset asserted mid-burst SHALL abort without a done pulse; after release the block accepts start on the first clk edge.

Configuration
REQ-028 Macro MODE_GEN_TIMEOUT_EN defined: after TO_CYC cycles in WAIT_F with no f_in, go to FIN with done=1, err=1.
REQ-029 Macro MODE_GEN_TIMEOUT_EN undefined: no timeout counter; WAIT_F waits for f_in indefinitely (only reset exits).

Verification
REQ-030 len=3, start pulse, conforming receiver -> do_out high 3 cycles, r_in seen, done=1 err=0 at cycle 7 after start.
REQ-031 len=1 -> do_out high 1 cycle, done=1 err=0 at cycle 5; then immediate second start len=2 accepted normally.
REQ-032 len=0 start -> no do_out, single-cycle done=1 err=1, busy never asserted.
REQ-033 With MODE_GEN_TIMEOUT_EN, TO_CYC=8, f_in held 0 -> done=1 err=1 exactly 8 cycles after entering WAIT_F; without macro, busy stays 1.
REQ-034 f_in pulsed without any r_in -> done=1 err=1; f_in injected during DRIVE -> err=1 at done.
REQ-035 rst_n pulsed low during DRIVE (len=10, cycle 4) -> do_out and busy drop immediately, no done; new start afterwards completes with err=0.
